// File: rtl/probe_trace_tx.sv
// probe_trace_tx: captures {tag, op1, op2, res} probe samples into a small record
// FIFO and streams each record as a framed 4-word valid/ready burst:
// header, op1, op2, res. The header carries a magic byte, an 8-bit
// sequence number and the record tag.
module probe_trace_tx #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [1:0]       tag,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [WIDTH-1:0] res,
  output logic             armed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic [15:0]      overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_OP1,
    S_OP2,
    S_RES
  } state_t;

  state_t state;

  logic [CW-1:0]    settle_cnt;
  logic [7:0]       seq;

  logic [1:0]       fifo_tag [DEPTH];
  logic [WIDTH-1:0] fifo_op1 [DEPTH];
  logic [WIDTH-1:0] fifo_op2 [DEPTH];
  logic [WIDTH-1:0] fifo_res [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [AW:0]      count;

  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push;
  logic             drop;

  // Saturating 16-bit increment for the drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Frame header: magic byte on top, sequence in [15:8], tag in [1:0].
  function automatic logic [WIDTH-1:0] make_header(input logic [7:0] s,
                                                   input logic [1:0] t);
    logic [WIDTH-1:0] h;
    h                 = '0;
    h[WIDTH-1 -: 8]   = 8'hA5;
    h[15:8]           = s;
    h[1:0]            = t;
    return h;
  endfunction

  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign rd_ptr_nxt = rd_ptr + AW'(1);

  // A record leaves the FIFO when its res word is accepted; a full FIFO can
  // still take a sample on that same edge because the slot frees up.
  assign pop  = out_valid & out_ready & (state == S_RES);
  assign push = armed & sample_en & (~fifo_full | pop);
  assign drop = armed & sample_en & fifo_full & ~pop;

  // Settle counter: arm capture a fixed number of edges after reset releases.
  always_ff @(posedge clock) begin
    if (reset) begin
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      if (settle_cnt != CW'(SETTLE)) settle_cnt <= settle_cnt + CW'(1);
      if (settle_cnt == CW'(SETTLE)) armed <= 1'b1;
    end
  end

  // Record storage; payload only, so no reset needed.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_tag[wr_ptr] <= tag;
      fifo_op1[wr_ptr] <= op1;
      fifo_op2[wr_ptr] <= op2;
      fifo_res[wr_ptr] <= res;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Count samples lost to a full FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_cnt <= '0;
    end else if (drop) begin
      overflow_cnt <= sat_inc16(overflow_cnt);
    end
  end

  // Framer FSM: all stream outputs are registered, so out_valid never depends
  // on out_ready within a cycle and words hold steady while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      seq       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state     <= S_HDR;
            out_valid <= 1'b1;
            out_data  <= make_header(seq, fifo_tag[rd_ptr]);
            out_sof   <= 1'b1;
            out_eof   <= 1'b0;
          end
        end
        S_HDR: begin
          if (out_ready) begin
            seq      <= seq + 8'd1;
            out_data <= fifo_op1[rd_ptr];
            out_sof  <= 1'b0;
            state    <= S_OP1;
          end
        end
        S_OP1: begin
          if (out_ready) begin
            out_data <= fifo_op2[rd_ptr];
            state    <= S_OP2;
          end
        end
        S_OP2: begin
          if (out_ready) begin
            out_data <= fifo_res[rd_ptr];
            out_eof  <= 1'b1;
            state    <= S_RES;
          end
        end
        S_RES: begin
          if (out_ready) begin
            out_eof <= 1'b0;
            // Another record already queued: chain its header with no bubble.
            if (count > (AW+1)'(1)) begin
              out_data <= make_header(seq, fifo_tag[rd_ptr_nxt]);
              out_sof  <= 1'b1;
              state    <= S_HDR;
            end else begin
              out_valid <= 1'b0;
              state     <= S_IDLE;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          out_sof   <= 1'b0;
          out_eof   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_probe_trace_tx.sv
// Directed bench for probe_trace_tx: arming, single frame, overflow and
// back-to-back drain, random stalls, sequence wrap, reset mid-frame.
module tb_probe_trace_tx;

  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             sample_en;
  logic [1:0]       tag;
  logic [WIDTH-1:0] op1, op2, res;
  logic             armed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sof, out_eof;
  logic [15:0]      overflow_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_seq  = 0;

  probe_trace_tx #(.WIDTH(WIDTH), .DEPTH(4), .SETTLE(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_en    (sample_en),
    .tag          (tag),
    .op1          (op1),
    .op2          (op2),
    .res          (res),
    .armed        (armed),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sof      (out_sof),
    .out_eof      (out_eof),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] hdr(input int s, input int t);
    return {8'hA5, 8'h00, 8'(s), 6'b0, 2'(t)};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset_arm;
    reset = 1'b1; sample_en = 1'b0; out_ready = 1'b0;
    tick; tick;
    reset = 1'b0;
    repeat (4) tick;
    exp_seq = 0;
    n_checks++;
    if (armed !== 1'b1) begin
      n_fail++; $display("FAIL rearm: armed=%b expected 1", armed);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; sample_en = 1'b1; out_ready = 1'b1;
    tag = 2'd3; op1 = 32'h11; op2 = 32'h22; res = 32'h33;
    repeat (3) tick;
    n_checks++;
    if ({armed, out_valid, out_sof, out_eof} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {armed, out_valid, out_sof, out_eof});
    end
    n_checks++;
    if (out_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", out_data);
    end
    n_checks++;
    if (overflow_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_ovf: got %h expected 0", overflow_cnt);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++;
      if (armed !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL settle_%0d: armed=%b valid=%b expected 0 0", i, armed, out_valid);
      end
    end
    tick;
    n_checks++;
    if (armed !== 1'b1) begin
      n_fail++; $display("FAIL arm_rise: armed=%b expected 1", armed);
    end
    n_checks++;
    if (overflow_cnt !== 16'h0) begin
      n_fail++; $display("FAIL unarmed_ovf: got %0d expected 0", overflow_cnt);
    end
    sample_en = 1'b0;
    tick;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL no_early_frame: valid=%b expected 0", out_valid);
    end
    exp_seq = 0;
  endtask

  task automatic test_single;
    logic [31:0] w [4];
    w[0] = 32'hA5000001; w[1] = 32'd5; w[2] = 32'd9; w[3] = 32'd14;
    out_ready = 1'b1;
    sample_en = 1'b1; tag = 2'd1; op1 = 32'd5; op2 = 32'd9; res = 32'd14;
    tick;
    sample_en = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_lat0: valid=%b expected 0", out_valid);
    end
    for (int p = 0; p < 4; p++) begin
      tick;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== w[p] || out_sof !== (p == 0) || out_eof !== (p == 3)) begin
        n_fail++;
        $display("FAIL single_w%0d: valid=%b data=%h sof=%b eof=%b expected 1 %h %b %b",
                 p, out_valid, out_data, out_sof, out_eof, w[p], (p == 0), (p == 3));
      end
    end
    tick;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_end: valid=%b expected 0", out_valid);
    end
    exp_seq++;
  endtask

  task automatic test_overflow;
    logic [1:0]  rt [5];
    logic [31:0] r1 [5], r2 [5], r3 [5];
    logic [31:0] ew;
    for (int i = 0; i < 4; i++) begin
      rt[i] = 2'(i); r1[i] = 32'h100 + i; r2[i] = 32'h200 + i; r3[i] = 32'h300 + i;
    end
    rt[4] = 2'd2; r1[4] = 32'h106; r2[4] = 32'h206; r3[4] = 32'h306;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample_en = 1'b1; tag = 2'(i);
      op1 = 32'h100 + i; op2 = 32'h200 + i; res = 32'h300 + i;
      tick;
    end
    sample_en = 1'b0;
    n_checks++;
    if (overflow_cnt !== 16'd2) begin
      n_fail++; $display("FAIL ovf_count: got %0d expected 2", overflow_cnt);
    end
    repeat (3) tick;
    n_checks++;
    if (out_valid !== 1'b1 || out_sof !== 1'b1 || out_data !== hdr(exp_seq, 0)) begin
      n_fail++; $display("FAIL ovf_stall_hdr: valid=%b sof=%b data=%h expected 1 1 %h",
                         out_valid, out_sof, out_data, hdr(exp_seq, 0));
    end
    out_ready = 1'b1;
    for (int wi = 0; wi < 20; wi++) begin
      int f, p;
      f = wi / 4; p = wi % 4;
      case (p)
        0:       ew = hdr(exp_seq + f, int'(rt[f]));
        1:       ew = r1[f];
        2:       ew = r2[f];
        default: ew = r3[f];
      endcase
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== ew || out_sof !== (p == 0) || out_eof !== (p == 3)) begin
        n_fail++;
        $display("FAIL drain_w%0d: valid=%b data=%h sof=%b eof=%b expected 1 %h %b %b",
                 wi, out_valid, out_data, out_sof, out_eof, ew, (p == 0), (p == 3));
      end
      if (wi == 3) begin
        sample_en = 1'b1; tag = 2'd2; op1 = 32'h106; op2 = 32'h206; res = 32'h306;
      end else begin
        sample_en = 1'b0;
      end
      tick;
    end
    sample_en = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_end: valid=%b expected 0", out_valid);
    end
    n_checks++;
    if (overflow_cnt !== 16'd2) begin
      n_fail++; $display("FAIL full_pop_push: ovf=%0d expected 2", overflow_cnt);
    end
    exp_seq += 5;
  endtask

  task automatic test_stall;
    logic [31:0] qw [12];
    logic        qs [12], qe [12];
    logic        pv, pr, ps, pe;
    logic [31:0] pd;
    int idx, cyc;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_en = 1'b1; tag = 2'(i + 3);
      op1 = 32'h400 + i; op2 = 32'h500 + i; res = 32'h600 + i;
      qw[4*i]   = hdr(exp_seq + i, (i + 3) % 4);
      qw[4*i+1] = 32'h400 + i; qw[4*i+2] = 32'h500 + i; qw[4*i+3] = 32'h600 + i;
      for (int p = 0; p < 4; p++) begin
        qs[4*i+p] = (p == 0); qe[4*i+p] = (p == 3);
      end
      tick;
    end
    sample_en = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 12 && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      pv = out_valid; pr = out_ready; pd = out_data; ps = out_sof; pe = out_eof;
      tick;
      cyc++;
      if (pv && pr) begin
        n_checks++;
        if (pd !== qw[idx] || ps !== qs[idx] || pe !== qe[idx]) begin
          n_fail++; $display("FAIL stall_word%0d: data=%h sof=%b eof=%b expected %h %b %b",
                             idx, pd, ps, pe, qw[idx], qs[idx], qe[idx]);
        end
        idx++;
      end else if (pv && !pr) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== pd || out_sof !== ps || out_eof !== pe) begin
          n_fail++; $display("FAIL stall_hold: valid=%b data=%h sof=%b eof=%b expected 1 %h %b %b",
                             out_valid, out_data, out_sof, out_eof, pd, ps, pe);
        end
      end
    end
    n_checks++;
    if (idx != 12) begin
      n_fail++; $display("FAIL stall_timeout: words=%0d expected 12", idx);
    end
    out_ready = 1'b1;
    tick;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_end: valid=%b expected 0", out_valid);
    end
    exp_seq += 3;
  endtask

  task automatic test_wrap;
    int hdrs, pushes, cyc;
    do_reset_arm;
    out_ready = 1'b1;
    hdrs = 0; pushes = 0; cyc = 0;
    while (hdrs < 258 && cyc < 3000) begin
      if (cyc % 4 == 0 && pushes < 258) begin
        sample_en = 1'b1; tag = 2'(pushes);
        op1 = 32'(pushes); op2 = 32'(pushes); res = 32'(pushes);
        pushes++;
      end else begin
        sample_en = 1'b0;
      end
      if (out_valid && out_sof) begin
        n_checks++;
        if (out_data !== hdr(hdrs % 256, hdrs % 4)) begin
          n_fail++; $display("FAIL wrap_hdr%0d: got %h expected %h", hdrs, out_data, hdr(hdrs % 256, hdrs % 4));
        end
        hdrs++;
      end
      tick;
      cyc++;
    end
    sample_en = 1'b0;
    n_checks++;
    if (hdrs != 258) begin
      n_fail++; $display("FAIL wrap_timeout: headers=%0d expected 258", hdrs);
    end
    repeat (8) tick;
    n_checks++;
    if (out_valid !== 1'b0 || overflow_cnt !== 16'd0) begin
      n_fail++; $display("FAIL wrap_end: valid=%b ovf=%0d expected 0 0", out_valid, overflow_cnt);
    end
    exp_seq = 258 % 256;
  endtask

  task automatic test_reset_midframe;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_en = 1'b1; tag = 2'd1;
      op1 = 32'h700 + i; op2 = 32'h800 + i; res = 32'h900 + i;
      tick;
    end
    sample_en = 1'b0;
    out_ready = 1'b1;
    tick; tick;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h800) begin
      n_fail++; $display("FAIL mid_op2: valid=%b data=%h expected 1 00000800", out_valid, out_data);
    end
    out_ready = 1'b0;
    reset = 1'b1;
    tick;
    n_checks++;
    if ({out_valid, armed, out_sof, out_eof} !== 4'b0000 || out_data !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset: valid=%b armed=%b sof=%b eof=%b data=%h expected all 0",
                         out_valid, armed, out_sof, out_eof, out_data);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick;
    n_checks++;
    if (armed !== 1'b1) begin
      n_fail++; $display("FAIL mid_rearm: armed=%b expected 1", armed);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_fifo_empty%0d: valid=%b expected 0", i, out_valid);
      end
    end
    sample_en = 1'b1; tag = 2'd2; op1 = 32'hA1; op2 = 32'hA2; res = 32'hA3;
    tick;
    sample_en = 1'b0;
    tick;
    n_checks++;
    if (out_valid !== 1'b1 || out_sof !== 1'b1 || out_data !== hdr(0, 2)) begin
      n_fail++; $display("FAIL mid_seq0: valid=%b sof=%b data=%h expected 1 1 %h",
                         out_valid, out_sof, out_data, hdr(0, 2));
    end
    repeat (4) tick;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_end: valid=%b expected 0", out_valid);
    end
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; out_ready = 1'b0;
    tag = '0; op1 = '0; op2 = '0; res = '0;
    test_reset;
    test_single;
    test_overflow;
    test_stall;
    test_wrap;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
